// File: rtl/sm_display_pkg.sv
// Shared definitions for the seven-segment scan controller: FSM states,
// segment bit positions and the hex-to-segment lookup table.
package sm_display_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_ON    = 1'b1
  } state_e;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // Segment vector {g,f,e,d,c,b,a}, 1 = lit, indexed by the hex value.
  localparam logic [6:0] HEX_SEG_TABLE [0:15] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    return HEX_SEG_TABLE[nibble];
  endfunction

endpackage

// File: rtl/sm_hex_scan_ctrl_if.sv
// CPU-side write channel of the scan controller: valid/ready handshake
// carrying the packed nibble word, digit enable mask and leading-zero flag.
interface sm_hex_scan_ctrl_if #(
  parameter int DIGITS = 8
);

  logic                  wr_valid;
  logic                  wr_ready;
  logic [4*DIGITS-1:0]   wr_data;
  logic [DIGITS-1:0]     wr_mask;
  logic                  wr_lz;

  modport master (
    output wr_valid,
    output wr_data,
    output wr_mask,
    output wr_lz,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_data,
    input  wr_mask,
    input  wr_lz,
    output wr_ready
  );

endinterface

// File: rtl/sm_hex_seg_decode.sv
// Combinational hex nibble to seven-segment decoder ({g,f,e,d,c,b,a}, 1 = lit).
module sm_hex_seg_decode
  import sm_display_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = hex_to_seg(nibble_i);

endmodule

// File: rtl/sm_hex_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller with double-buffered display
// data committed at frame boundaries, inter-digit dead-time and zero blanking.
module sm_hex_scan_ctrl
  import sm_display_pkg::*;
#(
  parameter int DIGITS       = 8,
  parameter int ON_CYCLES    = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  sm_hex_scan_ctrl_if.slave wr,
  output logic [6:0]        seg_out,
  output logic [DIGITS-1:0] digit_sel,
  output logic              frame_start
);

  localparam int MAX_CYC = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int IDX_W   = $clog2(DIGITS);

  localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

  if (DIGITS < 2 || DIGITS > 8) begin : g_bad_digits
    $error("sm_hex_scan_ctrl: DIGITS must be in 2..8");
  end
  if (ON_CYCLES < 1) begin : g_bad_on
    $error("sm_hex_scan_ctrl: ON_CYCLES must be >= 1");
  end
  if (BLANK_CYCLES < 1) begin : g_bad_blank
    $error("sm_hex_scan_ctrl: BLANK_CYCLES must be >= 1");
  end

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] act_data_q, act_data_d;
  logic [DIGITS-1:0]   act_mask_q, act_mask_d;
  logic                act_lz_q, act_lz_d;
  logic [4*DIGITS-1:0] sh_data_q, sh_data_d;
  logic [DIGITS-1:0]   sh_mask_q, sh_mask_d;
  logic                sh_lz_q, sh_lz_d;
  logic                pending_q, pending_d;
  logic [6:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   sel_q, sel_d;
  logic                fs_q, fs_d;

  logic                accept;
  logic                commit_edge;
  logic [DIGITS-1:0]   zero_from;
  logic [DIGITS-1:0]   lit_vec;
  logic [3:0]          cur_nib;
  logic [6:0]          dec_seg;

  assign accept      = wr.wr_valid && !pending_q;
  assign commit_edge = (state_q == ST_BLANK) && (cnt_q == BLANK_LAST) && (idx_q == '0);

  // Sequencing, commit and write capture. Accept and commit are exclusive
  // because a write can only be accepted while nothing is pending.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    act_data_d = act_data_q;
    act_mask_d = act_mask_q;
    act_lz_d   = act_lz_q;
    sh_data_d  = sh_data_q;
    sh_mask_d  = sh_mask_q;
    sh_lz_d    = sh_lz_q;
    pending_d  = pending_q;
    fs_d       = 1'b0;

    case (state_q)
      ST_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = ST_ON;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_ON: begin
        if (cnt_q == ON_LAST) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_BLANK;
        cnt_d   = '0;
      end
    endcase

    if (commit_edge) begin
      fs_d = 1'b1;
      if (pending_q) begin
        act_data_d = sh_data_q;
        act_mask_d = sh_mask_q;
        act_lz_d   = sh_lz_q;
        pending_d  = 1'b0;
      end
    end

    if (accept) begin
      sh_data_d = wr.wr_data;
      sh_mask_d = wr.wr_mask;
      sh_lz_d   = wr.wr_lz;
      pending_d = 1'b1;
    end
  end

  // A digit is suppressed when it and every digit to its left hold zero.
  always_comb begin
    zero_from = '0;
    lit_vec   = '0;
    for (int i = 0; i < DIGITS; i++) begin
      zero_from[i] = ((act_data_d >> (4 * i)) == '0);
      lit_vec[i]   = act_mask_d[i] && !(act_lz_d && (i > 0) && zero_from[i]);
    end
  end

  assign cur_nib = act_data_d[{idx_d, 2'b00} +: 4];

  sm_hex_seg_decode u_decode (
    .nibble_i (cur_nib),
    .seg_o    (dec_seg)
  );

  always_comb begin
    sel_d = '0;
    seg_d = '0;
    if (state_d == ST_ON && lit_vec[idx_d]) begin
      sel_d = {{(DIGITS-1){1'b0}}, 1'b1} << idx_d;
      seg_d = dec_seg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_BLANK;
      cnt_q      <= '0;
      idx_q      <= '0;
      act_data_q <= '0;
      act_mask_q <= '0;
      act_lz_q   <= 1'b0;
      sh_data_q  <= '0;
      sh_mask_q  <= '0;
      sh_lz_q    <= 1'b0;
      pending_q  <= 1'b0;
      seg_q      <= '0;
      sel_q      <= '0;
      fs_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      act_data_q <= act_data_d;
      act_mask_q <= act_mask_d;
      act_lz_q   <= act_lz_d;
      sh_data_q  <= sh_data_d;
      sh_mask_q  <= sh_mask_d;
      sh_lz_q    <= sh_lz_d;
      pending_q  <= pending_d;
      seg_q      <= seg_d;
      sel_q      <= sel_d;
      fs_q       <= fs_d;
    end
  end

  assign wr.wr_ready = ~pending_q;
  assign seg_out     = seg_q;
  assign digit_sel   = sel_q;
  assign frame_start = fs_q;

endmodule
